nand_flash_responder: RTL and testbench
=======================================

// Module: nand_flash_responder
// PURPOSE
//  Synthesizable NAND flash target model: the device end of the F_IO/CLE/ALE/REN/WEN/RB
//  bus driven by the NFC controller. Decodes command/address/data cycles, holds a small
//  page-organised byte array, and drives R/B# busy windows. Instantiated twice (flash A, B)
//  in the system bench/FPGA top so the controller (and its TMR copy) copy real data.
// PARAMETERS
//  PAGE_BYTES  512  bytes per page (column range 0..511; 9-bit column)
//  ROW_AW      4    page-address bits used; array holds 2**ROW_AW pages
//  T_R         25   clk cycles R/B# low after read address (page load)
//  T_PROG      200  clk cycles R/B# low after program confirm 10h
//  T_RST       10   clk cycles R/B# low after reset FFh
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst       in   1  asynchronous, active-low reset
//  F_IO_IN   in   8  bus value driven by controller
//  F_IO_OUT  out  8  read data to controller
//  F_IO_OE   out  1  1 = device drives bus (REN low in READ state)
//  F_CLE     in   1  command latch enable, active high
//  F_ALE     in   1  address latch enable, active high
//  F_REN     in   1  read enable, active low
//  F_WEN     in   1  write enable, active low
//  F_RB      out  1  ready(1)/busy(0)
// BEHAVIOUR
//  Reset (rst=0, async): F_IO_OUT=8'h00, F_IO_OE=0, F_RB=1, state IDLE, col=0, page=0,
//   busy counter=0. Array contents are NOT cleared.
//  Inputs registered once (wen_q, ren_q, io_q). Write strobe = F_WEN=1 & wen_q=0; the
//   latched byte is io_q (value in the last WEN-low cycle). Read strobe = F_REN=0 & ren_q=1.
//  Strobe class: CLE=1,ALE=0 -> command; ALE=1,CLE=0 -> address; both 0 -> data;
//   both 1 -> ignored.
//  States: IDLE, ADDR, BUSY, READ, PROG, STATUS.
//  Commands (accepted in any state unless BUSY; FFh accepted always):
//   00h/01h: half=0/1, -> ADDR (read).  80h: -> ADDR (program).  70h: -> STATUS.
//   10h: only in PROG -> BUSY for T_PROG, then IDLE. FFh: abort anything, col=0,
//   -> BUSY for T_RST, then IDLE. Any other code -> IDLE, no effect.
//  ADDR: 3 address strobes: A1 = column byte, A2 = row low, A3 = row high.
//   col = {half,A1} (half forced 0 for 80h); page = {A3,A2}[ROW_AW-1:0] (upper bits
//   ignored). After A3: read -> BUSY T_R -> READ; program -> PROG. A command strobe
//   before A3 aborts the sequence and is decoded normally. Extra address strobes ignored.
//  BUSY: F_RB=0 from the cycle after the final strobe for exactly T_x cycles, then F_RB=1
//   and next state. Address/data strobes and non-FFh commands ignored while busy.
//  READ: on read strobe, F_IO_OUT <= mem[page][col] next cycle; F_IO_OE=1 while F_REN=0
//   (one-cycle lag), 0 otherwise. col increments on F_REN rising edge; at PAGE_BYTES-1
//   wraps to 0, page unchanged. Data strobes in READ ignored.
//  PROG: each data strobe writes io_q to mem[page][col] immediately, col increments with
//   the same wrap rule. 10h only commits the busy window; data is already in the array.
//   Abort (FFh or another command) keeps bytes already written.
//  STATUS: read strobe returns {1'b0, F_RB, 6'b0} (bit0=0: pass); F_RB sampled at strobe.
//   Leaves STATUS on next command.
//  Simultaneous rst deassert and strobe: strobe ignored (wen_q/ren_q reset to 1).
//  Mem: PAGE_BYTES*2**ROW_AW x 8, one write or one read port per cycle, sync read.
// TESTING
//  1 rst low mid-T_PROG -> F_RB=1, F_IO_OE=0, F_IO_OUT=00 immediately; array keeps data.
//  2 80h, addr 00/03/00, data A5,5A,3C, 10h -> F_RB low exactly 200 clk; then 00h,
//    00/03/00 -> F_RB low 25 clk; 3 REN pulses return A5,5A,3C.
//  3 01h, addr FE/03/00 after writing page 3 cols 510,511 = 11,22 -> reads 11,22, then
//    col wraps: third read returns mem[3][0].
//  4 70h during T_PROG busy -> status 8'h00; after ready -> 8'h40.
//  5 FFh during T_R busy -> F_RB stays low T_RST=10 clk then high; state IDLE, REN pulses
//    give F_IO_OE=0.
//  6 00h, addr 05, then 80h before A3 -> read aborted, program sequence starts; row byte
//    0x1F with ROW_AW=4 selects page 15.

Source files
------------

// File: rtl/nand_flash_responder.sv
// NAND flash target model: decodes CLE/ALE/WEN/REN cycles,
// holds a small paged byte array and drives R/B# busy windows.
module nand_flash_responder #(
  parameter int PAGE_BYTES = 512,
  parameter int ROW_AW     = 4,
  parameter int T_R        = 25,
  parameter int T_PROG     = 200,
  parameter int T_RST      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] F_IO_IN,
  output logic [7:0] F_IO_OUT,
  output logic       F_IO_OE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_REN,
  input  logic       F_WEN,
  output logic       F_RB
);

  localparam int CW = $clog2(PAGE_BYTES);
  localparam int BW = 16;

  typedef enum logic [2:0] {
    IDLE, ADDR, BUSY, READ, PROG, STATUS
  } state_t;

  state_t state, state_n;
  state_t bnext, bnext_n;

  logic [BW-1:0]     cnt, cnt_n;
  logic [CW-1:0]     col, col_n, col_inc;
  logic [ROW_AW-1:0] page, page_n;
  logic [7:0]        row_lo, row_lo_n;
  logic [1:0]        acnt, acnt_n;
  logic              is_prog, is_prog_n;
  logic              half, half_n;
  logic              stat_en, stat_n;
  logic              wen_q, ren_q;
  logic [7:0]        io_q;
  logic [7:0]        out_q;
  logic              oe_q;
  logic              mem_we;

  logic [7:0] mem [PAGE_BYTES * (2 ** ROW_AW)];

  logic wstb, rstb, rrise;
  logic cmd_s, adr_s, dat_s;
  logic busy;

  assign wstb  = F_WEN & ~wen_q;
  assign rstb  = ~F_REN & ren_q;
  assign rrise = F_REN & ~ren_q;
  assign cmd_s = wstb & F_CLE & ~F_ALE;
  assign adr_s = wstb & F_ALE & ~F_CLE;
  assign dat_s = wstb & ~F_CLE & ~F_ALE;
  assign busy  = (state == BUSY);

  assign col_inc = (col == CW'(PAGE_BYTES - 1)) ? '0 : col + 1'b1;

  assign F_RB     = ~busy;
  assign F_IO_OUT = out_q;
  assign F_IO_OE  = oe_q;

  always_comb begin
    state_n   = state;
    bnext_n   = bnext;
    cnt_n     = cnt;
    col_n     = col;
    page_n    = page;
    row_lo_n  = row_lo;
    acnt_n    = acnt;
    is_prog_n = is_prog;
    half_n    = half;
    stat_n    = stat_en;
    mem_we    = 1'b0;

    if (busy) begin
      if (cnt == BW'(1)) state_n = bnext;
      else cnt_n = cnt - 1'b1;
    end

    // FFh overrides everything, including a running busy window
    if (cmd_s && io_q == 8'hFF) begin
      state_n = BUSY;
      bnext_n = IDLE;
      cnt_n   = BW'(T_RST);
      col_n   = '0;
      stat_n  = 1'b0;
    end else if (busy) begin
      if (cmd_s && io_q == 8'h70) stat_n = 1'b1;
    end else begin
      if (rrise && state == READ && !stat_en)
        col_n = col_inc;
      unique case (1'b1)
        cmd_s: begin
          stat_n = 1'b0;
          case (io_q)
            8'h00, 8'h01: begin
              state_n   = ADDR;
              is_prog_n = 1'b0;
              half_n    = io_q[0];
              acnt_n    = 2'd0;
            end
            8'h80: begin
              state_n   = ADDR;
              is_prog_n = 1'b1;
              half_n    = 1'b0;
              acnt_n    = 2'd0;
            end
            8'h70: begin
              state_n = STATUS;
              stat_n  = 1'b1;
            end
            8'h10: begin
              if (state == PROG) begin
                state_n = BUSY;
                bnext_n = IDLE;
                cnt_n   = BW'(T_PROG);
              end else begin
                state_n = IDLE;
              end
            end
            default: state_n = IDLE;
          endcase
        end
        adr_s: begin
          if (state == ADDR) begin
            case (acnt)
              2'd0: begin
                col_n  = CW'({half, io_q});
                acnt_n = 2'd1;
              end
              2'd1: begin
                row_lo_n = io_q;
                acnt_n   = 2'd2;
              end
              2'd2: begin
                page_n = ROW_AW'({io_q, row_lo});
                acnt_n = 2'd3;
                if (is_prog) begin
                  state_n = PROG;
                end else begin
                  state_n = BUSY;
                  bnext_n = READ;
                  cnt_n   = BW'(T_R);
                end
              end
              default: ;
            endcase
          end
        end
        dat_s: begin
          if (state == PROG) begin
            mem_we = 1'b1;
            col_n  = col_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bnext   <= IDLE;
      cnt     <= '0;
      col     <= '0;
      page    <= '0;
      row_lo  <= '0;
      acnt    <= '0;
      is_prog <= 1'b0;
      half    <= 1'b0;
      stat_en <= 1'b0;
      wen_q   <= 1'b1;
      ren_q   <= 1'b1;
      io_q    <= '0;
      out_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state   <= state_n;
      bnext   <= bnext_n;
      cnt     <= cnt_n;
      col     <= col_n;
      page    <= page_n;
      row_lo  <= row_lo_n;
      acnt    <= acnt_n;
      is_prog <= is_prog_n;
      half    <= half_n;
      stat_en <= stat_n;
      wen_q   <= F_WEN;
      ren_q   <= F_REN;
      io_q    <= F_IO_IN;
      oe_q    <= ~F_REN & ((state == READ) | stat_en);
      if (rstb) begin
        if (stat_en)
          out_q <= {1'b0, F_RB, 6'b0};
        else if (state == READ)
          out_q <= mem[{page, col}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{page, col}] <= io_q;
  end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder: program/read,
// wrap, status, abort and async reset scenarios.
module tb_nand_flash_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       oe;
  logic       cle = 1'b0;
  logic       ale = 1'b0;
  logic       ren = 1'b1;
  logic       wen = 1'b1;
  logic       rb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nand_flash_responder dut (
    .clk      (clk),
    .rst      (rst),
    .F_IO_IN  (io_in),
    .F_IO_OUT (io_out),
    .F_IO_OE  (oe),
    .F_CLE    (cle),
    .F_ALE    (ale),
    .F_REN    (ren),
    .F_WEN    (wen),
    .F_RB     (rb)
  );

  task automatic wr(input logic c, input logic a,
                    input logic [7:0] v);
    @(negedge clk);
    cle = c; ale = a; io_in = v; wen = 1'b0;
    @(negedge clk);
    wen = 1'b1;
    @(negedge clk);
    cle = 1'b0; ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] v);
    wr(1'b1, 1'b0, v);
  endtask

  task automatic adr(input logic [7:0] v);
    wr(1'b0, 1'b1, v);
  endtask

  task automatic dat(input logic [7:0] v);
    wr(1'b0, 1'b0, v);
  endtask

  task automatic rd(output logic [7:0] d, output logic o);
    @(negedge clk);
    ren = 1'b0;
    @(negedge clk);
    d = io_out; o = oe; ren = 1'b1;
    @(negedge clk);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (rb === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if (rb !== 1'b1) begin
      n_bad++; $display("FAIL reset_rb: got %b want 1", rb);
    end
    n_cmp++;
    if (oe !== 1'b0) begin
      n_bad++; $display("FAIL reset_oe: got %b want 0", oe);
    end
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_bad++; $display("FAIL reset_out: got %h want 00", io_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_prog_read;
    logic [7:0] exp [3];
    logic [7:0] d;
    logic o;
    int n;
    exp = '{8'hA5, 8'h5A, 8'h3C};
    cmd(8'h80); adr(8'h00); adr(8'h03); adr(8'h00);
    for (int i = 0; i < 3; i++) dat(exp[i]);
    cmd(8'h10);
    busy_len(n);
    n_cmp++;
    if (n !== 200) begin
      n_bad++; $display("FAIL prog_busy: got %0d want 200", n);
    end
    cmd(8'h00); adr(8'h00); adr(8'h03); adr(8'h00);
    busy_len(n);
    n_cmp++;
    if (n !== 25) begin
      n_bad++; $display("FAIL read_busy: got %0d want 25", n);
    end
    for (int i = 0; i < 3; i++) begin
      rd(d, o);
      n_cmp++;
      if (d !== exp[i]) begin
        n_bad++;
        $display("FAIL read_data%0d: got %h want %h", i, d, exp[i]);
      end
      n_cmp++;
      if (o !== 1'b1) begin
        n_bad++; $display("FAIL read_oe%0d: got %b want 1", i, o);
      end
    end
    n_cmp++;
    if (oe !== 1'b0) begin
      n_bad++; $display("FAIL oe_release: got %b want 0", oe);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp [4];
    logic [7:0] d;
    logic o;
    int n;
    exp = '{8'h11, 8'h22, 8'hA5, 8'h5A};
    cmd(8'h80); adr(8'hFF); adr(8'h03); adr(8'h00);
    for (int i = 0; i < 255; i++) dat(8'(i));
    dat(8'h11); dat(8'h22);
    cmd(8'h10);
    busy_len(n);
    cmd(8'h01); adr(8'hFE); adr(8'h03); adr(8'h00);
    busy_len(n);
    n_cmp++;
    if (n !== 25) begin
      n_bad++; $display("FAIL wrap_busy: got %0d want 25", n);
    end
    for (int i = 0; i < 4; i++) begin
      rd(d, o);
      n_cmp++;
      if (d !== exp[i]) begin
        n_bad++;
        $display("FAIL wrap_data%0d: got %h want %h", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_status;
    logic [7:0] d;
    logic o;
    int n;
    cmd(8'h80); adr(8'h00); adr(8'h04); adr(8'h00);
    dat(8'h77);
    cmd(8'h10);
    cmd(8'h70);
    rd(d, o);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++; $display("FAIL status_busy: got %h want 00", d);
    end
    n_cmp++;
    if (o !== 1'b1) begin
      n_bad++; $display("FAIL status_oe: got %b want 1", o);
    end
    busy_len(n);
    n_cmp++;
    if (rb !== 1'b1) begin
      n_bad++; $display("FAIL status_timeout: got rb %b want 1", rb);
    end
    rd(d, o);
    n_cmp++;
    if (d !== 8'h40) begin
      n_bad++; $display("FAIL status_ready: got %h want 40", d);
    end
  endtask

  task automatic test_ff_abort;
    logic [7:0] d;
    logic o;
    int n;
    cmd(8'h00); adr(8'h00); adr(8'h04); adr(8'h00);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rb !== 1'b0) begin
      n_bad++; $display("FAIL ff_pre_busy: got %b want 0", rb);
    end
    cmd(8'hFF);
    busy_len(n);
    n_cmp++;
    if (n !== 10) begin
      n_bad++; $display("FAIL ff_busy: got %0d want 10", n);
    end
    rd(d, o);
    n_cmp++;
    if (o !== 1'b0) begin
      n_bad++; $display("FAIL ff_idle_oe: got %b want 0", o);
    end
  endtask

  task automatic test_addr_abort;
    logic [7:0] d;
    logic o;
    int n;
    cmd(8'h00); adr(8'h05);
    cmd(8'h80);
    n_cmp++;
    if (rb !== 1'b1) begin
      n_bad++; $display("FAIL abort_rb: got %b want 1", rb);
    end
    adr(8'h02); adr(8'h1F); adr(8'h00);
    n_cmp++;
    if (rb !== 1'b1) begin
      n_bad++; $display("FAIL abort_prog_rb: got %b want 1", rb);
    end
    dat(8'h99);
    cmd(8'h10);
    busy_len(n);
    n_cmp++;
    if (n !== 200) begin
      n_bad++; $display("FAIL abort_prog_busy: got %0d want 200", n);
    end
    cmd(8'h00); adr(8'h02); adr(8'h0F); adr(8'h00);
    busy_len(n);
    rd(d, o);
    n_cmp++;
    if (d !== 8'h99) begin
      n_bad++; $display("FAIL page15_data: got %h want 99", d);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] d;
    logic o;
    int n;
    cmd(8'h80); adr(8'h00); adr(8'h07); adr(8'h00);
    dat(8'hC3);
    cmd(8'h10);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (rb !== 1'b0) begin
      n_bad++; $display("FAIL arst_pre_rb: got %b want 0", rb);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (rb !== 1'b1) begin
      n_bad++; $display("FAIL arst_rb: got %b want 1", rb);
    end
    n_cmp++;
    if (oe !== 1'b0) begin
      n_bad++; $display("FAIL arst_oe: got %b want 0", oe);
    end
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_bad++; $display("FAIL arst_out: got %h want 00", io_out);
    end
    @(negedge clk);
    rst = 1'b1;
    cmd(8'h00); adr(8'h00); adr(8'h07); adr(8'h00);
    busy_len(n);
    n_cmp++;
    if (n !== 25) begin
      n_bad++; $display("FAIL arst_read_busy: got %0d want 25", n);
    end
    rd(d, o);
    n_cmp++;
    if (d !== 8'hC3) begin
      n_bad++; $display("FAIL arst_keep: got %h want C3", d);
    end
  endtask

  initial begin
    test_reset;
    test_prog_read;
    test_wrap;
    test_status;
    test_ff_abort;
    test_addr_abort;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
